mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mips_pkg.sv | 93 +++++++++
 rtl/mc_ctrl_dec.sv | 64 ++++++
 rtl/mc_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode/funct constants, ALU operation codes and the per-state strobe table.
// Used by mc_ctrl and mc_ctrl_dec.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXEC_I    = 4'd10,
        S_I_WB      = 4'd11,
        S_JAL       = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;
    localparam logic [2:0] ALU_LUI   = 3'd6;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_we;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    // Moore strobe table; imm_op and jr are stable instruction-register fields.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [2:0] imm_op, input logic jr);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_rd = 1'b1; c.ir_we = 1'b1; c.pc_we = 1'b1; c.alu_src_b = 2'd1;
            end
            S_DECODE:    c.alu_src_b = 2'd3;
            S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            S_MEM_READ:  begin c.mem_rd = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:    begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WRITE: begin c.mem_wr = 1'b1; c.iord = 1'b1; end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1; c.alu_op = ALU_FUNCT;
                if (jr) begin c.pc_we = 1'b1; c.pc_src = 2'd3; end
            end
            S_R_WB: begin
                c.alu_src_a = 1'b1; c.alu_op = ALU_FUNCT; c.reg_we = 1'b1; c.reg_dst = 2'd1;
            end
            S_BRANCH:    begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'd1; end
            S_JUMP:      begin c.pc_we = 1'b1; c.pc_src = 2'd2; end
            S_EXEC_I:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = imm_op; end
            S_I_WB: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = imm_op; c.reg_we = 1'b1;
            end
            S_JAL: begin
                c.pc_we = 1'b1; c.pc_src = 2'd2; c.reg_we = 1'b1; c.reg_dst = 2'd2;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Next-state and immediate ALU-op decode for mc_ctrl.
// With MC_CTRL_WAIT_EN defined, FETCH/MEM_READ/MEM_WRITE hold until mem_ready_i.
import mips_pkg::*;

module mc_ctrl_dec (
    input  state_t     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output state_t     next_o,
    output logic       legal_o,
    output logic       jr_o,
    output logic [2:0] imm_op_o
);

    logic   ready;
    state_t dispatch;

`ifdef MC_CTRL_WAIT_EN
    assign ready = mem_ready_i;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready_i;
    assign ready = 1'b1;
`endif

    assign jr_o = (opcode_i == OP_RTYPE) && (funct_i == FN_JR);

    // Opcode dispatch target, legality and I-type ALU operation.
    always_comb begin
        dispatch = S_FETCH;
        legal_o  = 1'b1;
        imm_op_o = ALU_ADD;
        case (opcode_i)
            OP_LW, OP_SW:     dispatch = S_MEM_ADDR;
            OP_RTYPE:         dispatch = S_EXEC_R;
            OP_BEQ, OP_BNE:   dispatch = S_BRANCH;
            OP_J:             dispatch = S_JUMP;
            OP_JAL:           dispatch = S_JAL;
            OP_ADDI:          dispatch = S_EXEC_I;
            OP_SLTI: begin dispatch = S_EXEC_I; imm_op_o = ALU_SLT; end
            OP_ANDI: begin dispatch = S_EXEC_I; imm_op_o = ALU_AND; end
            OP_ORI:  begin dispatch = S_EXEC_I; imm_op_o = ALU_OR;  end
            OP_LUI:  begin dispatch = S_EXEC_I; imm_op_o = ALU_LUI; end
            default:          legal_o  = 1'b0;
        endcase
    end

    // Successor of the current state.
    always_comb begin
        next_o = S_FETCH;
        case (state_i)
            S_FETCH:     next_o = ready ? S_DECODE : S_FETCH;
            S_DECODE:    next_o = dispatch;
            S_MEM_ADDR:  next_o = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  next_o = ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: next_o = ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    next_o = jr_o ? S_FETCH : S_R_WB;
            S_EXEC_I:    next_o = S_I_WB;
            default:     next_o = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM with retired-instruction counter.
// Optional memory wait states: define MC_CTRL_WAIT_EN.
//
// state     | meaning
// FETCH     | read instruction, IR write, PC += 4
// DECODE    | register read, branch target computed
// MEM_ADDR  | effective address for lw/sw
// MEM_READ  | data memory read
// MEM_WB    | load result into rt
// MEM_WRITE | data memory write
// EXEC_R    | R-type ALU op, or jr PC write
// R_WB      | R-type result into rd
// BRANCH    | compare, conditional PC write
// JUMP      | PC <- jump target
// EXEC_I    | I-type ALU op
// I_WB      | I-type result into rt
// JAL       | PC <- jump target, r31 <- PC+4
import mips_pkg::*;

module mc_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic        iord,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  pc_src,
    output logic [1:0]  reg_dst,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    state_t      state_q, state_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] retired_q;
    logic        legal, jr, retire, br_take, mem_ok;
    logic [2:0]  imm_op;

    mc_ctrl_dec u_dec (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .funct_i     (funct),
        .mem_ready_i (mem_ready),
        .next_o      (state_d),
        .legal_o     (legal),
        .jr_o        (jr),
        .imm_op_o    (imm_op)
    );

    // Strobes are registered from the next state so they are glitch-free.
    assign ctrl_d = ctrl_of(state_d, imm_op, jr);
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_DECODE);

`ifdef MC_CTRL_WAIT_EN
    assign mem_ok = (state_q != S_FETCH) || mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    assign br_take = (state_q == S_BRANCH) &&
                     (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero));

    // State, registered strobes and retire counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_FETCH;
            ctrl_q    <= ctrl_of(S_FETCH, ALU_ADD, 1'b0);
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (retire) retired_q <= retired_q + 32'd1;
        end
    end

    assign ir_we      = ctrl_q.ir_we & mem_ok;
    assign pc_we      = (ctrl_q.pc_we & mem_ok) | br_take;
    assign iord       = ctrl_q.iord;
    assign mem_rd     = ctrl_q.mem_rd;
    assign mem_wr     = ctrl_q.mem_wr;
    assign reg_we     = ctrl_q.reg_we;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign pc_src     = ctrl_q.pc_src;
    assign reg_dst    = ctrl_q.reg_dst;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign illegal    = (state_q == S_DECODE) && !legal;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule
